// File: rtl/codec_slave.sv
// codec_slave: slave-side serial audio port with a 24-bit left-justified, MSB-first format.
//
// The master drives the bit clock (i_bclk), the frame clock (i_lrck) and the DAC data (i_sdin).
// This block oversamples those lines with i_clk. It deserialises the received left and right
// words, and it serialises the transmit words onto o_sdout.
//
// Parameters
//   SYNC_STAGES  i_clk flip-flops on i_bclk/i_lrck/i_sdin (0..3). Use 0 only when the master
//                itself runs on i_clk.
//
// Build option
//   CODEC_SLAVE_LOOPBACK_EN  when defined, the transmit words are the received words
//                            (an echo one frame later), and i_tx_left/i_tx_right are ignored.
//
// Ports
//   i_clk, i_rst_n            system clock; asynchronous active-low reset
//   i_bclk, i_lrck, i_sdin    serial bus from the master (i_lrck: 1 = left, 0 = right)
//   o_sdout                   serial data to the master, updated after the bclk falling edge
//   i_tx_left, i_tx_right     words to transmit
//   o_rx_left, o_rx_right     last complete received frame
//   o_rx_valid                one-cycle pulse when o_rx_left/o_rx_right update
//   o_frame_err               one-cycle pulse when a half-frame carries fewer than 24 bits
module codec_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bclk,
  input  logic        i_lrck,
  input  logic        i_sdin,
  output logic        o_sdout,
  input  logic [23:0] i_tx_left,
  input  logic [23:0] i_tx_right,
  output logic [23:0] o_rx_left,
  output logic [23:0] o_rx_right,
  output logic        o_rx_valid,
  output logic        o_frame_err
);

  localparam logic [4:0] WordBits = 5'd24;
  localparam logic [4:0] CntMax   = 5'd31;

  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StLeft  = 2'd1,
    StRight = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers: {bclk, lrck, sdin} travel together so they stay aligned.
  // ---------------------------------------------------------------------------
  logic [2:0] raw_in;
  logic [2:0] piped;
  assign raw_in = {i_bclk, i_lrck, i_sdin};

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign piped = raw_in;
    end else begin : g_sync
      logic [2:0] sync_q [SYNC_STAGES];
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= raw_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign piped = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // History of the two clock lines. Edges are decoded combinationally, in the same cycle
  // in which the pipelined value changes.
  logic [1:0] hist_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hist_q <= '0;
    else          hist_q <= piped[2:1];
  end

  logic bclk_rise, bclk_fall, lrck_rise, lrck_fall, sdin_s;
  assign bclk_rise = piped[2] & ~hist_q[1];
  assign bclk_fall = ~piped[2] & hist_q[1];
  assign lrck_rise = piped[1] & ~hist_q[0];
  assign lrck_fall = ~piped[1] & hist_q[0];
  assign sdin_s    = piped[0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] rx_shift_q, rx_shift_d;
  logic [23:0] tx_shift_q, tx_shift_d;
  logic [23:0] left_hold_q, left_hold_d;
  logic        left_ok_q, left_ok_d;
  logic [23:0] rx_left_q, rx_left_d;
  logic [23:0] rx_right_q, rx_right_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        sdout_q, sdout_d;

  logic        start_half, load_left, load_right, in_frame;
  logic [23:0] tx_left_src, tx_right_src;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    rx_left_d   = rx_left_q;
    rx_right_d  = rx_right_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    start_half  = 1'b0;
    load_left   = 1'b0;
    load_right  = 1'b0;
    in_frame    = (state_q != StSync);

    // Frame-clock edges come first. The count and shift register that are checked here
    // belong to the half that is closing.
    unique case (state_q)
      StSync: begin
        if (lrck_rise) begin
          state_d    = StLeft;
          start_half = 1'b1;
          load_left  = 1'b1;
        end
      end
      StLeft: begin
        if (lrck_fall) begin
          state_d    = StRight;
          start_half = 1'b1;
          load_right = 1'b1;
          if (cnt_q >= WordBits) begin
            left_hold_d = rx_shift_q;
            left_ok_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            left_ok_d   = 1'b0;
          end
        end
      end
      StRight: begin
        if (lrck_rise) begin
          state_d    = StLeft;
          start_half = 1'b1;
          load_left  = 1'b1;
          left_ok_d  = 1'b0;  // each left word pairs with exactly one right word
          if (cnt_q >= WordBits) begin
            if (left_ok_q) begin
              rx_left_d  = left_hold_q;
              rx_right_d = rx_shift_q;
              rx_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = StSync;
    endcase

    // Bit counter and receive shifter. A bclk rise that coincides with the frame-clock edge
    // is bit 0 of the new half.
    if (start_half) begin
      if (bclk_rise) begin
        cnt_d      = 5'd1;
        rx_shift_d = {rx_shift_q[22:0], sdin_s};
      end else begin
        cnt_d      = 5'd0;
      end
    end else if (in_frame && bclk_rise) begin
      if (cnt_q < WordBits) rx_shift_d = {rx_shift_q[22:0], sdin_s};
      if (cnt_q != CntMax)  cnt_d = cnt_q + 5'd1;
    end
  end

`ifdef CODEC_SLAVE_LOOPBACK_EN
  // Load from the next-state value so that a word completing in this very cycle is echoed
  // in the following frame.
  assign tx_left_src  = rx_left_d;
  assign tx_right_src = rx_right_d;
  logic unused_tx;
  assign unused_tx = ^{i_tx_left, i_tx_right};
`else
  assign tx_left_src  = i_tx_left;
  assign tx_right_src = i_tx_right;
`endif

  // Transmit shifter. The bclk fall that coincides with the frame-clock edge starts bit 23,
  // so it is not allowed to advance the freshly loaded word. The zero fill keeps o_sdout low
  // after bit 0.
  always_comb begin
    tx_shift_d = tx_shift_q;
    if (load_left) begin
      tx_shift_d = tx_left_src;
    end else if (load_right) begin
      tx_shift_d = tx_right_src;
    end else if (in_frame && bclk_fall) begin
      tx_shift_d = {tx_shift_q[22:0], 1'b0};
    end
    sdout_d = (state_d != StSync) & tx_shift_d[23];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StSync;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      rx_left_q   <= '0;
      rx_right_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sdout_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      rx_left_q   <= rx_left_d;
      rx_right_q  <= rx_right_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      sdout_q     <= sdout_d;
    end
  end

  assign o_sdout     = sdout_q;
  assign o_rx_left   = rx_left_q;
  assign o_rx_right  = rx_right_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: doc/codec_slave.md
CODEC_SLAVE -- requirements
Module: codec_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of i_clk flip-flops on i_bclk/i_lrck/i_sdin; legal values 0..3; use 0 only when the master is clocked by i_clk.
REQ-002 i_clk  in  1  system clock. Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
REQ-003 i_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_bclk  in  1  serial bit clock from master.
REQ-005 i_lrck  in  1  frame clock from master; 1 = left half, 0 = right half.
REQ-006 i_sdin  in  1  serial data from master (DAC direction); valid at the bclk rising edge.
REQ-007 o_sdout  out  1  serial data to master (ADC direction); changes after the bclk falling edge.
REQ-008 i_tx_left, i_tx_right  in  24 each  words to transmit, signed two's complement.
REQ-009 o_rx_left, o_rx_right  out  24 each  last complete received frame.
REQ-010 o_rx_valid  out  1  one-cycle pulse when o_rx_left/o_rx_right update.
REQ-011 o_frame_err  out  1  one-cycle pulse when a half-frame is shorter than 24 bits.

Function
REQ-012 i_bclk, i_lrck and i_sdin SHALL pass through identical SYNC_STAGES pipelines, followed by one history register for edge detection; edges SHALL be decoded in the same cycle that the pipelined value changes.
REQ-013 Frame format: left-justified, MSB first. Bit 23 occupies the first bclk period after the lrck edge. Each half-frame has 24 data bits; any further bclk periods (typically 1 pad bit, 25 per half) SHALL be ignored.
REQ-014 State machine: SYNC -> LEFT on the lrck rising edge; LEFT -> RIGHT on the lrck falling edge; RIGHT -> LEFT on the lrck rising edge; SYNC ignores all bclk activity.
REQ-015 A 5-bit bit counter SHALL clear on every lrck edge and increment on each bclk rising edge. It SHALL saturate at 31.
REQ-016 While the bit counter is below 24, the i_sdin sample taken at a bclk rising edge SHALL shift into the rx shift register (LSB in).
REQ-017 LEFT -> RIGHT transition: the rx shift register SHALL be latched into an internal left holding register if the count is 24 or more; otherwise o_frame_err SHALL pulse and the left half is marked invalid.
REQ-018 RIGHT -> LEFT transition with count of 24 or more and a valid left half: o_rx_left/o_rx_right SHALL update and o_rx_valid SHALL pulse in the same cycle.
REQ-019 RIGHT -> LEFT transition with count below 24: o_frame_err SHALL pulse and there SHALL be no o_rx_valid pulse.
REQ-020 An lrck edge and a bclk edge decoded in the same cycle SHALL be processed as the lrck edge first; the coincident rising edge SHALL count as bit 0 of the new half.
REQ-021 Tx: on the lrck rising edge, i_tx_left SHALL load the tx shift register and o_sdout SHALL equal bit 23 on the next cycle.
REQ-022 Tx: on the lrck falling edge, i_tx_right SHALL load the tx shift register and o_sdout SHALL equal bit 23 on the next cycle.
REQ-023 Each following bclk falling edge SHALL advance o_sdout to the next lower bit. After bit 0, o_sdout SHALL be 0 until the next lrck edge.
REQ-024 In SYNC, o_sdout SHALL be 0.
REQ-025 An lrck edge arriving mid-word SHALL abandon the current word with no error beyond REQ-017/REQ-019.

Reset
REQ-026 i_rst_n low SHALL asynchronously clear the following: state to SYNC, counter, shift registers, sync pipelines, o_sdout, o_rx_left, o_rx_right, o_rx_valid and o_frame_err.
REQ-027 Reset assertion mid-frame SHALL discard the partial frame. After release, no o_rx_valid SHALL occur before one complete LEFT and RIGHT pair.

Configuration
REQ-028 Macro CODEC_SLAVE_LOOPBACK_EN.
- Defined: the tx loads of REQ-021/REQ-022 SHALL take o_rx_left/o_rx_right instead of i_tx_left/i_tx_right, so received data echoes back one frame later; i_tx_* are unused.
- Undefined: i_tx_* are used as specified.

Verification
REQ-029 SYNC_STAGES=2, bclk = i_clk/10, 25 bits per half; send L=24'hA5A5A5, R=24'h5A5A5A -> one o_rx_valid with those exact values, o_frame_err never pulses.
REQ-030 i_tx_left=24'h800001, i_tx_right=24'h7FFFFE -> bits captured on master bclk rising edges read back 24'h800001 (left) and 24'h7FFFFE (right), pad bit 0.
REQ-031 SYNC_STAGES=0, driven by the existing 12 MHz codec master with input 24'h123456 -> o_rx_left=24'h123456 within 2 frames; master ADC capture equals i_tx_left.
REQ-032 Right half cut to 20 bclk -> o_frame_err pulses once, no o_rx_valid; the next full frame (24'h000001/24'hFFFFFF) is received correctly.
REQ-033 Reset pulsed at bit 12 of left, then a full frame 24'h0F0F0F/24'hF0F0F0 -> exactly one o_rx_valid, carrying those values.
REQ-034 CODEC_SLAVE_LOOPBACK_EN defined; frame N carries L=24'h111111 -> frame N+1 o_sdout left word = 24'h111111.
